// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// UART receiver: 8 data bits, no parity, one stop bit. The start bit is sampled
// at mid-bit, and each later bit is sampled one full bit period after the previous one.
module uart_rx #(
   parameter int clocks_per_bit = 434
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       pin,
   output logic [7:0] byte_received,
   output logic       valid,
   output logic       framing_error,
   output logic       busy
);

   localparam int CW = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(clocks_per_bit - 1);
   localparam logic [CW-1:0] C_HALF = CW'((clocks_per_bit - 1) / 2);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            r_sync1;
   logic            r_line;
   logic            r_line_d;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic [7:0]      r_byte;
   logic            r_valid;
   logic            r_ferr;
   logic            w_start_edge;
   logic            w_half;
   logic            w_last;

   assign w_start_edge = !r_line && r_line_d;
   assign w_half       = (r_cnt == C_HALF);
   assign w_last       = (r_cnt == C_LAST);

   always_ff @(posedge clock) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start_edge) w_state_next = S_START;
         S_START: if (w_half) w_state_next = r_line ? S_IDLE : S_DATA;
         S_DATA:  if (w_last && r_bit == 3'd7) w_state_next = S_STOP;
         S_STOP:  if (w_last) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy          = (r_state != S_IDLE);
      valid         = r_valid;
      framing_error = r_ferr;
      byte_received = r_byte;
   end

   // Datapath: synchronizer, bit-period counter, shift register and result pulses.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_sync1  <= 1'b1;
         r_line   <= 1'b1;
         r_line_d <= 1'b1;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_byte   <= '0;
         r_valid  <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_sync1  <= pin;
         r_line   <= r_sync1;
         r_line_d <= r_line;
         r_valid  <= 1'b0;
         r_ferr   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               r_bit <= '0;
            end
            S_START: r_cnt <= w_half ? '0 : r_cnt + 1'b1;
            S_DATA: begin
               if (w_last) begin
                  r_cnt   <= '0;
                  r_shift <= {r_line, r_shift[7:1]};
                  r_bit   <= r_bit + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (w_last) begin
                  r_cnt <= '0;
                  if (r_line) begin
                     r_byte  <= r_shift;
                     r_valid <= 1'b1;
                  end else begin
                     r_ferr <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter clocks_per_bit, default 434, meaning clock cycles per serial bit period; legal range >= 3.
REQ-002 SHALL provide port clock, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL provide port reset_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL provide port pin, input, 1, the asynchronous serial line; idles high.
REQ-005 SHALL provide port byte_received, output, 8, the last correctly framed data byte.
REQ-006 SHALL provide port valid, output, 1, a one-cycle pulse when byte_received is updated.
REQ-007 SHALL provide port framing_error, output, 1, a one-cycle pulse when the stop bit samples low.
REQ-008 SHALL provide port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-009 SHALL pass pin through a 2-flop synchronizer, reset to 1; "line" below means the synchronizer output.
REQ-010 SHALL keep a 1-cycle-delayed copy of line (line_d, reset 1) for edge detection.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP; the reset state is IDLE.
REQ-012 IDLE -> START SHALL occur when line==0 and line_d==1; the bit counter is cleared to 0 on entry.
REQ-013 A sustained low line without a preceding high SHALL NOT start a frame.
REQ-014 In START, the cycle counter SHALL increment each cycle.
REQ-015 In START, when the counter reaches (clocks_per_bit-1)/2 (integer division), line SHALL be sampled: 0 -> DATA with counter reset; 1 -> IDLE (false start, no output pulse).
REQ-016 In DATA, line SHALL be sampled each time the counter reaches clocks_per_bit-1 (counter then resets), giving 8 samples at mid-bit.
REQ-017 Data bits SHALL be shifted in LSB first.
REQ-018 After the 8th sample, the FSM SHALL go to STOP.
REQ-019 In STOP, line SHALL be sampled when the counter reaches clocks_per_bit-1, then the FSM SHALL return to IDLE.
REQ-020 If the stop sample is 1, the block SHALL load byte_received from the shift register and pulse valid for exactly one cycle, the cycle after the stop sample.
REQ-021 If the stop sample is 0, the block SHALL pulse framing_error for one cycle (same timing as valid), leave byte_received unchanged, and not assert valid.
REQ-022 After a framing error, a new frame SHALL require line to return high and fall again (per REQ-012).
REQ-023 valid and framing_error SHALL never be high in the same cycle.
REQ-024 Back-to-back frames with a single stop bit SHALL be received without loss, since IDLE detects the next start edge in the cycle after STOP exits.
REQ-025 The counter SHALL be wide enough for clocks_per_bit-1 ($clog2(clocks_per_bit)) and SHALL never wrap within a bit.
REQ-026 Latency from the pin start edge to the valid pulse SHALL be 2 (sync) + 1 (edge) + (clocks_per_bit-1)/2 + 9*clocks_per_bit + 1 cycles, within +-1 cycle of edge alignment.

Reset
REQ-027 While reset_n==0 at a rising clock edge, the block SHALL set: FSM=IDLE, counters=0, shift register=0, byte_received=8'h00, valid=0, framing_error=0, busy=0, synchronizer and line_d=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame without any valid or framing_error pulse.
REQ-029 After reset, a frame SHALL be received only if it starts after line has been seen high (REQ-012).

Verification (clocks_per_bit=3 unless noted)
REQ-030 SHALL test that serial 8'hB9 (start 0, bits 1,0,0,1,1,1,0,1 LSB first, stop 1), driven by uart at clocks_per_bit=3 with 3 cycles/bit, gives exactly one valid pulse, byte_received=8'hB9, framing_error=0.
REQ-031 SHALL test that a 1-cycle low glitch on an idle pin produces no valid, no framing_error, and busy drops within 3 cycles.
REQ-032 SHALL test that frame 8'h55 with stop bit forced 0 gives framing_error pulsed once, valid=0, and byte_received unchanged from its previous value.
REQ-033 SHALL test that back-to-back frames 8'h00 then 8'hFF, each with a single stop bit, give two valid pulses with byte_received 8'h00 then 8'hFF.
REQ-034 SHALL test that reset_n held low for 1 cycle during DATA of a frame gives no pulse, all outputs at reset values, and the next clean frame 8'hA5 received correctly.
REQ-035 SHALL test that with clocks_per_bit=434, frame 8'h3C gives valid at the cycle count given by REQ-026 (+-1).
